// File: rtl/block_data_memory_pkg.sv
// Shared definitions for the block data memory and the data cache that fronts it:
// controller states, default geometry/latency and the latency-counter width helper.
package block_data_memory_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEFAULT_ADDR_WIDTH  = 6;
  localparam int DEFAULT_BLOCK_BYTES = 4;
  localparam int DEFAULT_LATENCY     = 5;

  // Counter counts LATENCY-1 down to 0, so $clog2(LATENCY) bits suffice; keep at least one bit.
  function automatic int cnt_width(input int latency);
    return (latency <= 1) ? 1 : $clog2(latency);
  endfunction

endpackage

// File: rtl/block_data_memory_if.sv
// Read/write/busywait handshake between a cache controller (master) and the block memory (slave).
interface block_data_memory_if #(
  parameter int ADDR_WIDTH  = block_data_memory_pkg::DEFAULT_ADDR_WIDTH,
  parameter int BLOCK_BYTES = block_data_memory_pkg::DEFAULT_BLOCK_BYTES
) ();

  logic                     read;
  logic                     write;
  logic [ADDR_WIDTH-1:0]    address;
  logic [8*BLOCK_BYTES-1:0] writedata;
  logic [BLOCK_BYTES-1:0]   byteenable;
  logic [8*BLOCK_BYTES-1:0] readdata;
  logic                     busywait;
  logic                     error;

  modport master (
    output read, write, address, writedata, byteenable,
    input  readdata, busywait, error
  );

  modport slave (
    input  read, write, address, writedata, byteenable,
    output readdata, busywait, error
  );

endinterface

// File: rtl/block_memory_array.sv
// Block-organised byte storage: synchronous byte-enabled write, registered read,
// asynchronous clear of every byte and of the read register.
module block_memory_array #(
  parameter int ADDR_WIDTH  = 6,
  parameter int BLOCK_BYTES = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     i_we,
  input  logic                     i_re,
  input  logic [ADDR_WIDTH-1:0]    i_addr,
  input  logic [8*BLOCK_BYTES-1:0] i_wdata,
  input  logic [BLOCK_BYTES-1:0]   i_ben,
  output logic [8*BLOCK_BYTES-1:0] o_rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [BLOCK_BYTES-1:0][7:0] r_mem [DEPTH];
  logic [BLOCK_BYTES-1:0][7:0] r_rdata;
  logic [BLOCK_BYTES-1:0][7:0] w_wbytes;

  assign w_wbytes = i_wdata;
  assign o_rdata  = r_rdata;

  // NOTE: the whole array sits in the async-reset branch because a reset must leave every
  // byte reading 0; this forces flop storage rather than an inferred RAM macro.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_rdata <= '0;
    end else begin
      if (i_we) begin
        for (int k = 0; k < BLOCK_BYTES; k++) begin
          if (i_ben[k]) begin
            r_mem[i_addr][k] <= w_wbytes[k];
          end
        end
      end
      if (i_re) begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

endmodule

// File: rtl/block_data_memory.sv
// Block data memory top: request capture, LATENCY-cycle countdown and IDLE/BUSY/DONE
// handshake in front of the byte-enabled block array.
module block_data_memory
  import block_data_memory_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int BLOCK_BYTES = DEFAULT_BLOCK_BYTES,
  parameter int LATENCY     = DEFAULT_LATENCY
) (
  input  logic               clock,
  input  logic               reset,
  block_data_memory_if.slave bus
);

  localparam int CNT_W = cnt_width(LATENCY);

  state_e                   r_state;
  logic [CNT_W-1:0]         r_count;
  logic                     r_op_write;
  logic [ADDR_WIDTH-1:0]    r_addr;
  logic [8*BLOCK_BYTES-1:0] r_wdata;
  logic [BLOCK_BYTES-1:0]   r_ben;
  logic                     r_error;

  logic                     w_complete;
  logic                     w_we;
  logic                     w_re;
  logic [8*BLOCK_BYTES-1:0] w_rdata;

  assign w_complete = (r_state == ST_BUSY) && (r_count == '0);
  assign w_we       = w_complete && r_op_write;
  assign w_re       = w_complete && !r_op_write;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_count    <= '0;
      r_op_write <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_ben      <= '0;
      r_error    <= 1'b0;
    end else begin
      r_error <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.read ^ bus.write) begin
            r_op_write <= bus.write;
            r_addr     <= bus.address;
            r_wdata    <= bus.writedata;
            r_ben      <= bus.byteenable;
            r_count    <= CNT_W'(LATENCY - 1);
            r_state    <= ST_BUSY;
          end else if (bus.read && bus.write) begin
            r_error <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (r_count == '0) begin
            r_state <= ST_DONE;
          end else begin
            r_count <= r_count - 1'b1;
          end
        end
        // DONE gives the requester one idle cycle to drop read/write before re-sampling.
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: the default assignment first keeps this combinational block from inferring a latch.
  always_comb begin
    bus.busywait = 1'b0;
    case (r_state)
      ST_IDLE: bus.busywait = bus.read ^ bus.write;
      ST_BUSY: bus.busywait = 1'b1;
      default: bus.busywait = 1'b0;
    endcase
  end

  block_memory_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .BLOCK_BYTES(BLOCK_BYTES)
  ) u_array (
    .clock  (clock),
    .reset  (reset),
    .i_we   (w_we),
    .i_re   (w_re),
    .i_addr (r_addr),
    .i_wdata(r_wdata),
    .i_ben  (r_ben),
    .o_rdata(w_rdata)
  );

  assign bus.readdata = w_rdata;
  assign bus.error    = r_error;

endmodule

// File: tb/tb_block_data_memory.sv
// Directed bench: default-geometry instance plus a LATENCY=1, 16-byte-block instance.
module tb_block_data_memory;

  localparam int LAT_A = 5;
  localparam int LAT_B = 1;

  logic clock;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  block_data_memory_if #(.ADDR_WIDTH(6), .BLOCK_BYTES(4))  bus_a ();
  block_data_memory_if #(.ADDR_WIDTH(6), .BLOCK_BYTES(16)) bus_b ();

  block_data_memory #(.ADDR_WIDTH(6), .BLOCK_BYTES(4), .LATENCY(LAT_A)) dut_a (
    .clock(clock), .reset(reset), .bus(bus_a.slave)
  );

  block_data_memory #(.ADDR_WIDTH(6), .BLOCK_BYTES(16), .LATENCY(LAT_B)) dut_b (
    .clock(clock), .reset(reset), .bus(bus_b.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete access on instance A; counts busy negedges after capture, ends in DONE with requests dropped.
  task automatic access_a(input logic wr, input logic [5:0] addr, input logic [31:0] wd,
                          input logic [3:0] be, input string tag);
    int n;
    @(negedge clock);
    bus_a.read = !wr; bus_a.write = wr;
    bus_a.address = addr; bus_a.writedata = wd; bus_a.byteenable = be;
    @(posedge clock);
    n = 0;
    @(negedge clock);
    while (bus_a.busywait && n < 20) begin
      n++;
      @(negedge clock);
    end
    check({tag, "_busy_cycles"}, 128'(n), 128'(LAT_A));
    bus_a.read = 1'b0; bus_a.write = 1'b0;
  endtask

  task automatic access_b(input logic wr, input logic [5:0] addr, input logic [127:0] wd,
                          input logic [15:0] be, input string tag);
    int n;
    @(negedge clock);
    bus_b.read = !wr; bus_b.write = wr;
    bus_b.address = addr; bus_b.writedata = wd; bus_b.byteenable = be;
    @(posedge clock);
    n = 0;
    @(negedge clock);
    while (bus_b.busywait && n < 20) begin
      n++;
      @(negedge clock);
    end
    check({tag, "_busy_cycles"}, 128'(n), 128'(LAT_B));
    bus_b.read = 1'b0; bus_b.write = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1;
    bus_a.read = 1'b0; bus_a.write = 1'b0; bus_a.address = '0; bus_a.writedata = '0; bus_a.byteenable = '0;
    bus_b.read = 1'b0; bus_b.write = 1'b0; bus_b.address = '0; bus_b.writedata = '0; bus_b.byteenable = '0;
    repeat (2) @(negedge clock);
    check("rst_readdata", 128'(bus_a.readdata), 128'h0);
    check("rst_busywait", 128'(bus_a.busywait), 128'h0);
    check("rst_error",    128'(bus_a.error),    128'h0);
    reset = 1'b0;

    // Read of an untouched block after reset.
    access_a(1'b0, 6'h05, 32'h0, 4'h0, "rd05");
    check("rd05_data", 128'(bus_a.readdata), 128'h0);

    // Full write, readdata unaffected by the write, then read back.
    access_a(1'b1, 6'h3F, 32'hDEADBEEF, 4'b1111, "wr3f");
    check("wr3f_rd_unchanged", 128'(bus_a.readdata), 128'h0);
    access_a(1'b0, 6'h3F, 32'h0, 4'h0, "rd3f");
    check("rd3f_data", 128'(bus_a.readdata), 128'hDEADBEEF);

    // Partial write with byteenable 0101.
    access_a(1'b1, 6'h3F, 32'h11223344, 4'b0101, "wr3f_part");
    access_a(1'b0, 6'h3F, 32'h0, 4'h0, "rd3f_part");
    check("rd3f_part_data", 128'(bus_a.readdata), 128'hDE22BE44);

    // read and write together in IDLE: error pulse, no access.
    @(negedge clock);
    bus_a.read = 1'b1; bus_a.write = 1'b1; bus_a.address = 6'h3F; bus_a.writedata = 32'h0; bus_a.byteenable = 4'hF;
    #1 check("both_busywait", 128'(bus_a.busywait), 128'h0);
    @(negedge clock);
    check("both_error_hi", 128'(bus_a.error), 128'h1);
    check("both_busywait2", 128'(bus_a.busywait), 128'h0);
    bus_a.read = 1'b0; bus_a.write = 1'b0;
    @(negedge clock);
    check("both_error_lo", 128'(bus_a.error), 128'h0);
    access_a(1'b0, 6'h3F, 32'h0, 4'h0, "rd3f_after_err");
    check("rd3f_after_err_data", 128'(bus_a.readdata), 128'hDE22BE44);

    // Write with no bytes enabled still takes the full latency and changes nothing.
    access_a(1'b1, 6'h3F, 32'hFFFFFFFF, 4'b0000, "wr_be0");
    access_a(1'b0, 6'h3F, 32'h0, 4'h0, "rd_be0");
    check("rd_be0_data", 128'(bus_a.readdata), 128'hDE22BE44);

    // Inputs change and write drops mid-BUSY: captured write still completes.
    @(negedge clock);
    bus_a.write = 1'b1; bus_a.address = 6'h10; bus_a.writedata = 32'hA5A5A5A5; bus_a.byteenable = 4'hF;
    @(posedge clock);
    @(negedge clock);
    bus_a.write = 1'b0; bus_a.address = 6'h11; bus_a.writedata = 32'h0; bus_a.byteenable = 4'h0;
    #1 check("mid_busy_still_busy", 128'(bus_a.busywait), 128'h1);
    n = 0;
    while (bus_a.busywait && n < 20) begin
      n++;
      @(negedge clock);
    end
    check("mid_busy_done", 128'(bus_a.busywait), 128'h0);
    access_a(1'b0, 6'h11, 32'h0, 4'h0, "rd11");
    check("rd11_data", 128'(bus_a.readdata), 128'h0);
    access_a(1'b0, 6'h10, 32'h0, 4'h0, "rd10");
    check("rd10_data", 128'(bus_a.readdata), 128'hA5A5A5A5);

    // Reset while the write counter is at 2: no partial write, everything cleared.
    @(negedge clock);
    bus_a.write = 1'b1; bus_a.address = 6'h20; bus_a.writedata = 32'hCAFEF00D; bus_a.byteenable = 4'hF;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    bus_a.write = 1'b0;
    #1;
    check("rstmid_readdata", 128'(bus_a.readdata), 128'h0);
    check("rstmid_busywait", 128'(bus_a.busywait), 128'h0);
    @(negedge clock);
    reset = 1'b0;
    access_a(1'b0, 6'h20, 32'h0, 4'h0, "rd20");
    check("rd20_data", 128'(bus_a.readdata), 128'h0);
    access_a(1'b0, 6'h3F, 32'h0, 4'h0, "rd3f_cleared");
    check("rd3f_cleared_data", 128'(bus_a.readdata), 128'h0);

    // LATENCY=1, 16-byte blocks: full and partial writes, then reset mid-BUSY.
    access_b(1'b1, 6'h02, 128'h00112233_44556677_8899AABB_CCDDEEFF, 16'hFFFF, "b_wr02");
    access_b(1'b0, 6'h02, 128'h0, 16'h0, "b_rd02");
    check("b_rd02_data", bus_b.readdata, 128'h00112233_44556677_8899AABB_CCDDEEFF);
    access_b(1'b1, 6'h02, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 16'h8001, "b_wr02_part");
    access_b(1'b0, 6'h02, 128'h0, 16'h0, "b_rd02_part");
    check("b_rd02_part_data", bus_b.readdata, 128'hFF112233_44556677_8899AABB_CCDDEEFF);
    @(negedge clock);
    bus_b.write = 1'b1; bus_b.address = 6'h02; bus_b.writedata = 128'h12345678_12345678_12345678_12345678;
    bus_b.byteenable = 16'hFFFF;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    bus_b.write = 1'b0;
    #1 check("b_rstmid_readdata", bus_b.readdata, 128'h0);
    @(negedge clock);
    reset = 1'b0;
    access_b(1'b0, 6'h02, 128'h0, 16'h0, "b_rd02_cleared");
    check("b_rd02_cleared_data", bus_b.readdata, 128'h0);

    repeat (2) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
